texture_fetch: RTL
==================

# texture_fetch

Texture fetch unit that supplies the fragment shader's texel-color input. Accepts one texture-coordinate request at a time, converts the fixed-point (u,v) pair to a texel address, performs a single-word read over the memory request/grant/read-valid interface, unpacks the RGBA8888 word into per-channel lanes, and holds the texel on a valid/ready output until it is consumed. The block sits between fragment generation and the fragment shader's texel input.

## Interface
- DATA_WIDTH, 32, lane width of coordinates and output channels
- VEC_SIZE, 4, output channel count (R,G,B,A); must be 4
- ADDR_WIDTH, 32, memory address width
- FRAC_BITS, 16, fractional bits of coordinates; 1.0 = 1<<FRAC_BITS
- TEX_W_LOG2, 8, log2 texture width in texels (≤ FRAC_BITS)
- TEX_H_LOG2, 8, log2 texture height in texels (≤ FRAC_BITS)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  coordinate request valid
- o_req_ready  out  1  block can accept a request
- i_tex_coord  in  [1:0][DATA_WIDTH-1:0]  [0]=u, [1]=v, signed two's-complement fixed point
- i_tex_base  in  ADDR_WIDTH  texture byte base address, sampled with the request
- o_mem_req  out  1  memory read request
- o_mem_addr  out  ADDR_WIDTH  byte address of texel word
- i_mem_gnt  in  1  request accepted by memory
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  32  texel word, byte0=R, byte1=G, byte2=B, byte3=A
- o_texel_valid  out  1  texel output valid
- o_texel_color  out  [VEC_SIZE-1:0][DATA_WIDTH-1:0]  channel c = zero-extended rdata[8c+7:8c]
- i_texel_ready  in  1  consumer accepts texel

## Operation
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE: o_req_ready=1. On i_req_valid&o_req_ready, latch computed address -> REQ.
- REQ: o_mem_req=1, o_mem_addr stable. On i_mem_gnt -> WAIT. Held indefinitely without grant.
- WAIT: on i_mem_rvalid, register unpacked color -> OUT. i_mem_rvalid outside WAIT is ignored.
- OUT: o_texel_valid=1, o_texel_color stable. On i_texel_ready -> IDLE.
- Texel index: x from u, y from v; x = u[FRAC_BITS-1 : FRAC_BITS-TEX_W_LOG2] for in-range u; y likewise with TEX_H_LOG2.
- Address: i_tex_base + (((y << TEX_W_LOG2) + x) << 2), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH).
- Out-of-range handling is set by Configuration.

## Timing
- Reset values: o_req_ready=0 while rst_n low, 1 after release (IDLE); o_mem_req=0; o_mem_addr=0; o_texel_valid=0; o_texel_color=0.
- Minimum latency: accept cycle N, o_mem_req high N+1; gnt at N+1, rvalid at N+2 earliest, o_texel_valid at N+3.
- Grant is sampled only while o_mem_req=1; rvalid in the same cycle as gnt is not counted.
- Back-to-back throughput: one texel per 4 cycles minimum. No new request is accepted until OUT completes, including the ready cycle; next accept is the cycle after return to IDLE.
- Reset mid-operation: state returns to IDLE immediately, and all outputs take their reset values. A late rvalid for the dropped read is ignored.

## Configuration
- TEX_WRAP_EN defined: repeat addressing. x and y always take the fractional bits as above, regardless of sign or integer part. For example, u=-0.25 gives x = W·0.75.
- TEX_WRAP_EN undefined: clamp addressing. A negative coordinate gives index 0. A coordinate ≥ 1.0 gives index W-1 (or H-1). Otherwise the coordinate uses the fractional bits.

## Structure
- Package tex_pkg: FSM state enum (IDLE, REQ, WAIT, OUT), TEXEL_BYTES=4, CHANNEL_BITS=8.
- Sub-module tex_addr_gen (combinational): coords + base -> byte address, and contains the TEX_WRAP_EN logic.
- Top: FSM, request latch, and unpack/output register.

## Test plan
- Basic fetch: base=0x1000, u=0x00008000 (0.5), v=0x00004000 (0.25), immediate gnt, rdata=0x44332211 one cycle later -> o_mem_addr=0x1000+((64·256+128)·4)=0x11200, o_texel_color={0x44,0x33,0x22,0x11} (A..R), valid at N+3.
- Stalls: gnt delayed 5 cycles, rvalid delayed 3 cycles, ready delayed 4 cycles. Required response: o_mem_addr and o_texel_color stay stable throughout, o_req_ready=0 the whole time, and exactly one memory request is issued.
- Out-of-range coordinates: u=0x00018000 (1.5), v=0xFFFFC000 (-0.25). With TEX_WRAP_EN -> x=128, y=192. Without it -> x=255, y=0.
- Spurious rvalid: pulse i_mem_rvalid while in IDLE and REQ -> no state change and no o_texel_valid.
- Reset mid-operation: assert rst_n low in WAIT, release, then send a late rvalid -> all outputs stay 0, o_req_ready=1, and the next request completes normally.
- Back-to-back requests with i_texel_ready tied high and zero-latency memory -> a new accept every 4 cycles, and each texel matches its address.

Source files
------------

// File: rtl/tex_pkg.sv
// rtl/tex_pkg.sv - shared types and constants for the texture fetch unit
package tex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } tex_state_e;

    localparam int TEXEL_BYTES  = 4;
    localparam int CHANNEL_BITS = 8;
    localparam int TEXEL_SHIFT  = $clog2(TEXEL_BYTES);

endpackage

// File: rtl/tex_addr_gen.sv
// rtl/tex_addr_gen.sv - (u,v) fixed point to texel byte address; TEX_WRAP_EN selects repeat vs clamp
module tex_addr_gen
    import tex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int TEX_W_LOG2 = 8,
    parameter int TEX_H_LOG2 = 8
) (
    input  logic [1:0][DATA_WIDTH-1:0] i_tex_coord,
    input  logic [ADDR_WIDTH-1:0]      i_tex_base,
    output logic [ADDR_WIDTH-1:0]      o_addr
);

    logic [DATA_WIDTH-1:0] u;
    logic [DATA_WIDTH-1:0] v;
    logic [TEX_W_LOG2-1:0] x;
    logic [TEX_H_LOG2-1:0] y;
    logic [ADDR_WIDTH-1:0] texel_idx;
    logic                  unused_coord_bits;

    assign u = i_tex_coord[0];
    assign v = i_tex_coord[1];

`ifdef TEX_WRAP_EN
    // Repeat: the integer part and sign are simply discarded.
    assign x = u[FRAC_BITS-1 -: TEX_W_LOG2];
    assign y = v[FRAC_BITS-1 -: TEX_H_LOG2];
`else
    always_comb begin
        x = u[FRAC_BITS-1 -: TEX_W_LOG2];
        y = v[FRAC_BITS-1 -: TEX_H_LOG2];
        if (u[DATA_WIDTH-1]) begin
            x = '0;
        end else if (|u[DATA_WIDTH-2:FRAC_BITS]) begin
            x = '1;
        end
        if (v[DATA_WIDTH-1]) begin
            y = '0;
        end else if (|v[DATA_WIDTH-2:FRAC_BITS]) begin
            y = '1;
        end
    end
`endif

    assign texel_idx = (ADDR_WIDTH'(y) << TEX_W_LOG2) + ADDR_WIDTH'(x);
    assign o_addr    = i_tex_base + (texel_idx << TEXEL_SHIFT);

    // Sub-texel fraction bits never reach the address.
    assign unused_coord_bits = ^{u, v};

endmodule

// File: rtl/texture_fetch.sv
// rtl/texture_fetch.sv - single-texel fetch FSM with RGBA8888 unpack; optional TEX_WRAP_EN
module texture_fetch
    import tex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VEC_SIZE   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int TEX_W_LOG2 = 8,
    parameter int TEX_H_LOG2 = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic [1:0][DATA_WIDTH-1:0]         i_tex_coord,
    input  logic [ADDR_WIDTH-1:0]              i_tex_base,
    output logic                               o_mem_req,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    input  logic                               i_mem_gnt,
    input  logic                               i_mem_rvalid,
    input  logic [31:0]                        i_mem_rdata,
    output logic                               o_texel_valid,
    output logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] o_texel_color,
    input  logic                               i_texel_ready
);

    tex_state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] color_q, color_d;
    logic [ADDR_WIDTH-1:0]               calc_addr;
    logic                                req_ready;

    tex_addr_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .TEX_W_LOG2 (TEX_W_LOG2),
        .TEX_H_LOG2 (TEX_H_LOG2)
    ) u_addr_gen (
        .i_tex_coord (i_tex_coord),
        .i_tex_base  (i_tex_base),
        .o_addr      (calc_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            color_q <= color_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        color_d       = color_q;
        req_ready     = 1'b0;
        o_mem_req     = 1'b0;
        o_texel_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (i_req_valid) begin
                    addr_d  = calc_addr;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    for (int c = 0; c < VEC_SIZE; c++) begin
                        color_d[c] = DATA_WIDTH'(i_mem_rdata[c*CHANNEL_BITS +: CHANNEL_BITS]);
                    end
                    state_d = OUT;
                end
            end
            OUT: begin
                o_texel_valid = 1'b1;
                if (i_texel_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State already sits in IDLE during reset, so readiness is gated by rst_n itself.
    assign o_req_ready   = req_ready & rst_n;
    assign o_mem_addr    = addr_q;
    assign o_texel_color = color_q;

endmodule
